// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - observation bus between counter side and count_monitor (optional err_snap via COUNT_MON_SNAPSHOT_EN)
interface count_monitor_if #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8
);
  logic [WIDTH-1:0]      count;
  logic [WIDTH-1:0]      cmp_val;
  logic                  err_clr;
  logic                  wrap;
  logic                  match;
  logic                  step_err;
  logic [WRAP_CNT_W-1:0] wrap_cnt;
  logic [7:0]            err_cnt;
  logic                  locked;
  logic                  fault;
`ifdef COUNT_MON_SNAPSHOT_EN
  logic [2*WIDTH-1:0]    err_snap;
`endif

  modport master (
    output count, cmp_val, err_clr,
    input  wrap, match, step_err, wrap_cnt, err_cnt, locked, fault
`ifdef COUNT_MON_SNAPSHOT_EN
    , input err_snap
`endif
  );

  modport slave (
    input  count, cmp_val, err_clr,
    output wrap, match, step_err, wrap_cnt, err_cnt, locked, fault
`ifdef COUNT_MON_SNAPSHOT_EN
    , output err_snap
`endif
  );
endinterface

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - step/wrap/match checker for a free-running up-counter; COUNT_MON_SNAPSHOT_EN adds err_snap
module count_monitor #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8,
  parameter int LOCK_N     = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int STALL_OK   = 1
) (
  input  logic              clk,
  input  logic              res,
  count_monitor_if.slave    mon
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]      MAX_VAL   = '1;
  localparam logic [WIDTH-1:0]      ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_CNT_W-1:0] ONE_WC    = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]            LOCK_N_L  = 8'(LOCK_N);
  localparam logic [7:0]            ERR_LIM_L = 8'(ERR_LIMIT);
  localparam logic                  STALL_B   = (STALL_OK != 0);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [7:0]            good_run_q, good_run_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                  wrap_q, wrap_d;
  logic                  match_q, match_d;
  logic                  step_err_q, step_err_d;
  logic                  locked_q, locked_d;
  logic                  fault_q, fault_d;
`ifdef COUNT_MON_SNAPSHOT_EN
  logic [2*WIDTH-1:0]    snap_q, snap_d;
  logic                  snap_taken_q, snap_taken_d;
`endif

  logic [WIDTH-1:0] prev_inc;
  logic [7:0]       run_inc;
  logic [7:0]       err_inc;
  logic             step_adv;
  logic             step_ok_stall;

  assign prev_inc      = prev_q + ONE_W;
  assign run_inc       = good_run_q + 8'd1;
  assign err_inc       = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
  assign step_adv      = (mon.count == prev_inc);
  assign step_ok_stall = STALL_B && (mon.count == prev_q);

  // Next-state and next-output computation for the monitor FSM
  always_comb begin
    state_d    = state_q;
    prev_d     = mon.count;
    good_run_d = good_run_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    match_d    = 1'b0;
    step_err_d = 1'b0;
`ifdef COUNT_MON_SNAPSHOT_EN
    snap_d       = snap_q;
    snap_taken_d = snap_taken_q;
    if (mon.err_clr) begin
      snap_d       = '0;
      snap_taken_d = 1'b0;
    end
`endif

    case (state_q)
      ST_INIT: begin
        // First live sample only primes prev
        state_d = ST_TRACK;
        if (mon.err_clr) err_cnt_d = 8'd0;
      end
      ST_TRACK, ST_LOCKED: begin
        if (mon.err_clr) err_cnt_d = 8'd0;
        if (prev_q == MAX_VAL && mon.count == '0) begin
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt_q + ONE_WC;
        end
        match_d = (mon.count == mon.cmp_val) && (mon.count != prev_q);
        if (step_adv) begin
          if (state_q == ST_TRACK) begin
            good_run_d = run_inc;
            if (run_inc >= LOCK_N_L) state_d = ST_LOCKED;
          end
        end else if (!step_ok_stall) begin
          step_err_d = 1'b1;
          good_run_d = 8'd0;
          state_d    = ST_TRACK;
          // A simultaneous clear wins, so the error neither counts nor faults
          if (!mon.err_clr) begin
            err_cnt_d = err_inc;
            if (err_inc >= ERR_LIM_L) state_d = ST_FAULT;
`ifdef COUNT_MON_SNAPSHOT_EN
            if (!snap_taken_q) begin
              snap_d       = {prev_q, mon.count};
              snap_taken_d = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        // FAULT is sticky until cleared; counters and pulses are frozen
        if (mon.err_clr) begin
          state_d    = ST_INIT;
          err_cnt_d  = 8'd0;
          good_run_d = 8'd0;
        end
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    fault_d  = (state_d == ST_FAULT);
  end

  // Register all state and outputs; res low restarts alongside the counter
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= ST_INIT;
      prev_q     <= '0;
      good_run_q <= 8'd0;
      err_cnt_q  <= 8'd0;
      wrap_cnt_q <= '0;
      wrap_q     <= 1'b0;
      match_q    <= 1'b0;
      step_err_q <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
`ifdef COUNT_MON_SNAPSHOT_EN
      snap_q       <= '0;
      snap_taken_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_run_q <= good_run_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      wrap_q     <= wrap_d;
      match_q    <= match_d;
      step_err_q <= step_err_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
`ifdef COUNT_MON_SNAPSHOT_EN
      snap_q       <= snap_d;
      snap_taken_q <= snap_taken_d;
`endif
    end
  end

  assign mon.wrap     = wrap_q;
  assign mon.match    = match_q;
  assign mon.step_err = step_err_q;
  assign mon.wrap_cnt = wrap_cnt_q;
  assign mon.err_cnt  = err_cnt_q;
  assign mon.locked   = locked_q;
  assign mon.fault    = fault_q;
`ifdef COUNT_MON_SNAPSHOT_EN
  assign mon.err_snap = snap_q;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed bench for count_monitor with a behavioural reference model
module tb_count_monitor;
  localparam int WIDTH      = 4;
  localparam int WRAP_CNT_W = 8;
  localparam int LOCK_N     = 4;
  localparam int ERR_LIMIT  = 3;
  localparam int STALL_OK   = 1;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W)) bus ();

  count_monitor #(
    .WIDTH(WIDTH), .WRAP_CNT_W(WRAP_CNT_W), .LOCK_N(LOCK_N),
    .ERR_LIMIT(ERR_LIMIT), .STALL_OK(STALL_OK)
  ) dut (
    .clk(clk),
    .res(res),
    .mon(bus.slave)
  );

  // Reference model: mode 0 init, 1 tracking, 2 locked, 3 fault
  int         m_mode;
  int         m_prev;
  int         m_run;
  int         m_err;
  int         m_wraps;
  int         m_snap;
  bit         m_taken;
  bit         e_wrap, e_match, e_serr;

  always @(posedge clk) begin : model
    int  c;
    bit  adv;
    bit  legal;
    c = int'(bus.count);
    e_wrap  = 1'b0;
    e_match = 1'b0;
    e_serr  = 1'b0;
    if (!res) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_err = 0; m_wraps = 0;
      m_snap = 0; m_taken = 1'b0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1;
        if (bus.err_clr) m_err = 0;
      end else if (m_mode == 3) begin
        if (bus.err_clr) begin m_mode = 0; m_err = 0; m_run = 0; end
      end else begin
        adv   = (c == (m_prev + 1) % 16);
        legal = adv || (STALL_OK != 0 && c == m_prev);
        if (m_prev == 15 && c == 0) begin
          e_wrap  = 1'b1;
          m_wraps = (m_wraps + 1) % 256;
        end
        e_match = (c == int'(bus.cmp_val)) && (c != m_prev);
        if (bus.err_clr) m_err = 0;
        if (!legal) begin
          e_serr = 1'b1;
          m_run  = 0;
          m_mode = 1;
          if (!bus.err_clr) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            if (m_err >= ERR_LIMIT) m_mode = 3;
            if (!m_taken) begin m_snap = m_prev * 16 + c; m_taken = 1'b1; end
          end
        end else if (adv && m_mode == 1) begin
          m_run = m_run + 1;
          if (m_run >= LOCK_N) m_mode = 2;
        end
      end
      if (bus.err_clr) begin m_snap = 0; m_taken = 1'b0; end
      m_prev = c;
    end
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
  endtask

  task automatic compare();
    logic [31:0] act, exp;
    act = '0;
    exp = '0;
    act[20:0] = {bus.wrap, bus.match, bus.step_err, bus.wrap_cnt, bus.err_cnt, bus.locked, bus.fault};
    exp[20:0] = {e_wrap, e_match, e_serr, 8'(m_wraps), 8'(m_err), (m_mode == 2), (m_mode == 3)};
`ifdef COUNT_MON_SNAPSHOT_EN
    act[28:21] = bus.err_snap;
    exp[28:21] = 8'(m_snap);
`endif
    check("model", act, exp);
  endtask

  task automatic step(input logic [3:0] c, input logic clr, input logic r);
    bus.count   = c;
    bus.err_clr = clr;
    res         = r;
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic ramp(input int from, input int to);
    for (int i = from; i <= to; i++) step(4'(i), 1'b0, 1'b1);
  endtask

  initial begin
    bus.count   = 4'd0;
    bus.cmp_val = 4'hF;
    bus.err_clr = 1'b0;
    res         = 1'b0;

    // Reset state
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("rst_flags", {29'd0, bus.wrap, bus.match, bus.step_err}, 32'd0);
    check("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("rst_locked_fault", {30'd0, bus.locked, bus.fault}, 32'd0);

    // Case 1: init capture, stall, ramp to lock, single wrap
    step(4'd0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1);
    ramp(1, 3);
    check("c1_not_locked_at_3", 32'(bus.locked), 32'd0);
    step(4'd4, 1'b0, 1'b1);
    check("c1_locked_at_4", 32'(bus.locked), 32'd1);
    ramp(5, 15);
    step(4'd0, 1'b0, 1'b1);
    check("c1_wrap_pulse", 32'(bus.wrap), 32'd1);
    check("c1_wrap_cnt", 32'(bus.wrap_cnt), 32'd1);
    step(4'd1, 1'b0, 1'b1);
    check("c1_wrap_one_cycle", 32'(bus.wrap), 32'd0);
    check("c1_no_errors", 32'(bus.err_cnt), 32'd0);

    // Case 2: match fires once on a held value
    bus.cmp_val = 4'd5;
    ramp(2, 5);
    check("c2_match_first", 32'(bus.match), 32'd1);
    step(4'd5, 1'b0, 1'b1);
    check("c2_match_held1", 32'(bus.match), 32'd0);
    step(4'd5, 1'b0, 1'b1);
    check("c2_match_held2", 32'(bus.match), 32'd0);
    step(4'd6, 1'b0, 1'b1);
    check("c2_no_errors", 32'(bus.err_cnt), 32'd0);

    // Case 3: jump while locked, then relock
    ramp(7, 15);
    ramp(0, 3);
    check("c3_wrap_cnt2", 32'(bus.wrap_cnt), 32'd2);
    step(4'd7, 1'b0, 1'b1);
    check("c3_step_err", 32'(bus.step_err), 32'd1);
    check("c3_err_cnt", 32'(bus.err_cnt), 32'd1);
    check("c3_unlocked", 32'(bus.locked), 32'd0);
    ramp(8, 10);
    check("c3_still_tracking", 32'(bus.locked), 32'd0);
    step(4'd11, 1'b0, 1'b1);
    check("c3_relocked", 32'(bus.locked), 32'd1);

    // Case 4: clear, three errors into fault, frozen in fault, recover
    step(4'd12, 1'b1, 1'b1);
    check("c4_clear_keeps_lock", {24'd0, bus.err_cnt}, 32'd0);
    check("c4_clear_lock", 32'(bus.locked), 32'd1);
    step(4'd1, 1'b0, 1'b1);
    step(4'd5, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1);
    check("c4_fault", 32'(bus.fault), 32'd1);
    check("c4_err_cnt3", 32'(bus.err_cnt), 32'd3);
    step(4'd14, 1'b0, 1'b1);
    step(4'd15, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b1);
    check("c4_no_wrap_in_fault", 32'(bus.wrap), 32'd0);
    check("c4_wrap_cnt_frozen", 32'(bus.wrap_cnt), 32'd2);
    check("c4_err_cnt_frozen", 32'(bus.err_cnt), 32'd3);
    step(4'd1, 1'b1, 1'b1);
    check("c4_fault_cleared", {30'd0, bus.locked, bus.fault}, 32'd0);
    check("c4_err_cleared", 32'(bus.err_cnt), 32'd0);
    ramp(2, 5);
    check("c4_not_yet_locked", 32'(bus.locked), 32'd0);
    step(4'd6, 1'b0, 1'b1);
    check("c4_relocked", 32'(bus.locked), 32'd1);

    // Clear coinciding with the error that would reach the limit
    step(4'd9, 1'b0, 1'b1);
    step(4'd13, 1'b0, 1'b1);
    check("clr_race_pre", 32'(bus.err_cnt), 32'd2);
    step(4'd0, 1'b1, 1'b1);
    check("clr_race_step_err", 32'(bus.step_err), 32'd1);
    check("clr_race_err_cnt", 32'(bus.err_cnt), 32'd0);
    check("clr_race_no_fault", 32'(bus.fault), 32'd0);

    // Case 5: reset mid-operation, then restart
    ramp(1, 8);
    check("c5_locked_before_rst", 32'(bus.locked), 32'd1);
    step(4'd9, 1'b1, 1'b0);
    check("c5_rst_all_zero", {11'd0, bus.wrap, bus.match, bus.step_err, bus.wrap_cnt, bus.err_cnt, bus.locked, bus.fault}, 32'd0);
    bus.cmp_val = 4'd0;
    step(4'd0, 1'b0, 1'b1);
    check("c5_init_no_pulse", {29'd0, bus.wrap, bus.match, bus.step_err}, 32'd0);
    ramp(1, 3);
    check("c5_not_locked_at_3", 32'(bus.locked), 32'd0);
    step(4'd4, 1'b0, 1'b1);
    check("c5_relocked_at_4", 32'(bus.locked), 32'd1);

    // Case 6: snapshot of first error, held, then cleared
    step(4'd2, 1'b1, 1'b1);
    step(4'd6, 1'b0, 1'b1);
    step(4'd1, 1'b0, 1'b1);
    check("c6_err_cnt2", 32'(bus.err_cnt), 32'd2);
`ifdef COUNT_MON_SNAPSHOT_EN
    check("c6_snap_held", 32'(bus.err_snap), 32'h26);
`endif
    step(4'd2, 1'b1, 1'b1);
    check("c6_err_cleared", 32'(bus.err_cnt), 32'd0);
`ifdef COUNT_MON_SNAPSHOT_EN
    check("c6_snap_cleared", 32'(bus.err_snap), 32'h00);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream checker/consumer for the free-running WIDTH-bit up-counter output (`count`).
- Samples the counter value every clock, validates each step, detects wrap-around and compare matches, and tracks lock and fault status.
- Provides event pulses and health status to the rest of the design.

Parameters:
WIDTH, 4, width of monitored count bus
WRAP_CNT_W, 8, width of wrap-event counter
LOCK_N, 4, consecutive legal advancing steps required to declare lock (1..255)
ERR_LIMIT, 3, step errors that force FAULT (1..255)
STALL_OK, 1, 1 = repeated value (count == prev) is legal; 0 = repeat is a step error

Ports:
clk  input  1  system clock, all logic on rising edge
res  input  1  reset, synchronous, active-low (res=0 at a rising edge resets block)
count  input  WIDTH  counter value under observation
cmp_val  input  WIDTH  compare value for match pulse
err_clr  input  1  clears err_cnt; exits FAULT
wrap  output  1  one-cycle pulse on legal max->0 step
match  output  1  one-cycle pulse on fresh arrival of count == cmp_val
step_err  output  1  one-cycle pulse on illegal step
wrap_cnt  output  WRAP_CNT_W  number of wraps seen, modulo 2^WRAP_CNT_W
err_cnt  output  8  step errors since reset or clear, saturating at 255
locked  output  1  high in LOCKED state
fault  output  1  high in FAULT state

Behaviour:
- Reset (res=0 at edge): state=INIT; prev=0; good_run=0; all outputs 0.
- Output timing: all outputs registered and updated at the same edge that samples `count`.
  - The "current sample" is the value of `count` at that edge; `prev` is the sample from the previous edge.
  - Pulses are high for exactly one cycle.
- Legal step (all arithmetic modulo 2^WIDTH):
  - count == prev+1 is legal.
  - count == prev is legal only when STALL_OK=1.
  - Anything else is illegal.
  - max->0 is legal (it is the +1 case) and is a wrap.
- `prev` loads the current sample every edge out of reset, in every state.
- States (2-bit encoding): INIT=0, TRACK=1, LOCKED=2, FAULT=3.
- INIT:
  - First edge with res=1 captures prev only.
  - No step check, no wrap, no match.
  - Goes to TRACK.
- TRACK:
  - Legal advancing step (+1): good_run++.
  - Legal stall: good_run unchanged.
  - When good_run reaches LOCK_N: go to LOCKED, locked=1 at that edge.
  - Illegal step: step_err pulse, err_cnt++, good_run=0, stay TRACK; if err_cnt reaches ERR_LIMIT, go to FAULT instead.
- LOCKED:
  - Legal steps: stay LOCKED.
  - Illegal step: step_err pulse, err_cnt++, good_run=0, locked=0, go to TRACK; if err_cnt reaches ERR_LIMIT, go to FAULT.
- FAULT:
  - Sticky: fault=1.
  - wrap, match and step_err are suppressed; err_cnt is frozen.
  - err_clr=1 -> INIT, err_cnt=0, good_run=0.
- wrap (TRACK/LOCKED only):
  - Fires when prev == 2^WIDTH-1 and count == 0.
  - wrap_cnt++ at the same edge; wrap_cnt rolls over without a flag.
- match (TRACK/LOCKED only):
  - Fires when count == cmp_val and count != prev.
  - A stalled value does not re-fire.
  - A match on an illegal step still fires.
- err_clr outside FAULT:
  - err_cnt=0; state is unaffected.
  - If an illegal step occurs in the same cycle: err_cnt=0 (clear wins), step_err still pulses, and the state transition still applies, but FAULT cannot be entered that cycle.
- res=0 mid-operation overrides everything, including err_clr. The monitor shares `res` with the upstream counter, so both restart together.

Optional Feature:
COUNT_MON_SNAPSHOT_EN
- Defined:
  - Adds output port err_snap [2*WIDTH-1:0].
  - Loads {prev, count} on the first illegal step after reset or err_clr; holds until the next reset or err_clr.
  - Reset value 0; err_clr clears it to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (defaults: WIDTH=4, LOCK_N=4, ERR_LIMIT=3, STALL_OK=1):
1. Reset 2 cycles, then count 0,0,1,2,...,15,0,1 -> locked=1 at the edge sampling 4; single wrap pulse at the edge sampling 0 after 15; wrap_cnt=1; step_err never high.
2. cmp_val=5; ramp that holds 5 for 3 cycles -> exactly one match pulse, on the first edge sampling 5; no step_err.
3. While locked, jump 3->7 -> step_err pulse, err_cnt=1, locked=0, state=TRACK; then 8,9,10,11 -> locked=1 at the edge sampling 11.
4. Three illegal jumps -> fault=1, state=3, err_cnt=3. A later 15->0 gives no wrap and wrap_cnt is unchanged. err_clr=1 -> state=INIT, err_cnt=0; next ramp relocks.
5. res=0 at the edge where count=9 while LOCKED with wrap_cnt=2 -> after that edge all outputs are 0 and state=INIT. With res=1 and a ramp from 0, the first sample only captures prev (no pulses), and relock follows case 1.
6. With COUNT_MON_SNAPSHOT_EN defined, steps 2->6 then 6->1 -> err_snap=8'h26 and is held after the second error; err_clr -> err_snap=0.
